adc_channel_mux: RTL and testbench

ADC_CHANNEL_MUX -- requirements
Module: adc_channel_mux

---
 rtl/adc_channel_mux.sv | 150 +++++++++++++++
 tb/tb_adc_channel_mux.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adc_channel_mux.sv
// Two-lane ADC channel selector with fixed or round-robin scan selection and a one-deep output register.
// Optional dropped-frame reporting (ovf / drop_cnt) is built only when ADC_CHANNEL_MUX_OVF_EN is defined.

module adc_channel_mux_lane #(
  parameter int N_CH  = 24,
  parameter int DW    = 18,
  parameter int SEL_W = 6,
  parameter int LANE  = 0
) (
  input  logic [2*N_CH*DW-1:0] frame,
  input  logic [SEL_W-1:0]     ch,
  output logic [DW-1:0]        sample
);
  always_comb begin
    sample = '0;
    for (int k = 1; k <= N_CH; k++)
      if (ch == SEL_W'(k)) sample = frame[(2*k-2+LANE)*DW +: DW];
  end
endmodule

module adc_channel_mux #(
  parameter int N_CH  = 24,
  parameter int DW    = 18,
  parameter int SEL_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_CH*DW-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     sel_a,
  input  logic [SEL_W-1:0]     sel_b,
  input  logic                 scan_mode,
  output logic [DW-1:0]        data_out_a,
  output logic [DW-1:0]        data_out_b,
  output logic [SEL_W-1:0]     ch_a,
  output logic [SEL_W-1:0]     ch_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  output logic [15:0]          drop_cnt,
  input  logic                 ovf_clr
);
  localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH);

  // Out-of-range selects fold onto channel 1 so ch_a/ch_b always name a real channel.
  function automatic logic [SEL_W-1:0] map_sel(input logic [SEL_W-1:0] s);
    return (s == '0 || s > CH_LAST) ? CH_ONE : s;
  endfunction

  logic                      out_valid_q, out_valid_d;
  logic [1:0][DW-1:0]        data_q, data_d;
  logic [1:0][SEL_W-1:0]     ch_q, ch_d;
  logic [SEL_W-1:0]          scan_q, scan_d;
  logic [1:0][SEL_W-1:0]     sel_ch;
  logic [1:0][DW-1:0]        lane_data;
  logic                      accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign sel_ch[0] = scan_mode ? scan_q : map_sel(sel_a);
  assign sel_ch[1] = scan_mode ? scan_q : map_sel(sel_b);

  for (genvar l = 0; l < 2; l++) begin : g_lane
    adc_channel_mux_lane #(.N_CH(N_CH), .DW(DW), .SEL_W(SEL_W), .LANE(l)) u_lane (
      .frame  (data_in),
      .ch     (sel_ch[l]),
      .sample (lane_data[l])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    ch_d        = ch_q;
    scan_d      = scan_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_d      = lane_data;
      ch_d        = sel_ch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (!scan_mode)  scan_d = CH_ONE;
    else if (accept) scan_d = (scan_q == CH_LAST) ? CH_ONE : scan_q + CH_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ch_q        <= {CH_ONE, CH_ONE};
      scan_q      <= CH_ONE;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      scan_q      <= scan_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out_a = data_q[0];
  assign data_out_b = data_q[1];
  assign ch_a       = ch_q[0];
  assign ch_b       = ch_q[1];

`ifdef ADC_CHANNEL_MUX_OVF_EN
  logic        ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        drop;

  assign drop = in_valid && !in_ready;

  // A drop coinciding with a clear counts as the first drop after the clear.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)               cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = cnt_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
  assign drop_cnt       = '0;
`endif

endmodule

// File: tb/tb_adc_channel_mux.sv
// Directed bench for adc_channel_mux (N_CH=24, DW=18): fixed/scan select, backpressure, drops, reset.
module tb_adc_channel_mux;
  localparam int N_CH = 24, DW = 18, SEL_W = 6;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, scan_mode, out_valid, out_ready, ovf, ovf_clr;
  logic [2*N_CH*DW-1:0] frame;
  logic [SEL_W-1:0]     sel_a, sel_b, ch_a, ch_b;
  logic [DW-1:0]        data_out_a, data_out_b;
  logic [15:0]          drop_cnt;
  int                   n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  adc_channel_mux #(.N_CH(N_CH), .DW(DW), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .data_in(frame), .in_valid(in_valid), .in_ready(in_ready),
    .sel_a(sel_a), .sel_b(sel_b), .scan_mode(scan_mode),
    .data_out_a(data_out_a), .data_out_b(data_out_b), .ch_a(ch_a), .ch_b(ch_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  // Sample value encodes seed, lane and channel so any misrouting shows up.
  function automatic logic [DW-1:0] lv(input int seed, input int k, input int lane);
    logic [7:0] s; logic [5:0] kk; logic ln;
    s = 8'(seed); kk = 6'(k); ln = lane[0];
    return {s, ln, kk, 3'b101};
  endfunction

  task automatic build(input int seed);
    for (int k = 1; k <= N_CH; k++) begin
      frame[(2*k-2)*DW +: DW] = lv(seed, k, 0);
      frame[(2*k-1)*DW +: DW] = lv(seed, k, 1);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                         input int ca, input int cb, input logic ev);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".data_a"}, 32'(data_out_a), 32'(ea));
    chk({tag, ".data_b"}, 32'(data_out_b), 32'(eb));
    chk({tag, ".ch_a"}, 32'(ch_a), 32'(ca));
    chk({tag, ".ch_b"}, 32'(ch_b), 32'(cb));
  endtask

  initial begin
    logic [DW-1:0] ha, hb;
    rst = 1; in_valid = 0; out_ready = 0; scan_mode = 0; ovf_clr = 0;
    sel_a = '0; sel_b = '0; frame = '0;
    tick(); tick();
    rst = 0;
    chk_out("reset", '0, '0, 1, 1, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.ovf", 32'(ovf), 32'd0);
    chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);

    // Fixed select, single pulse
    build(1); sel_a = 6'd3; sel_b = 6'd24; out_ready = 1; in_valid = 1;
    ha = frame[89:72]; hb = frame[863:846];
    tick(); in_valid = 0;
    chk_out("fixed3_24", lv(1, 3, 0), lv(1, 24, 1), 3, 24, 1'b1);
    chk("fixed3_24.slice_a", 32'(data_out_a), 32'(ha));
    chk("fixed3_24.slice_b", 32'(data_out_b), 32'(hb));
    tick();
    chk("fixed3_24.vld_drop", 32'(out_valid), 32'd0);

    // Out-of-range selects fold to channel 1
    build(2); sel_a = 6'd0; sel_b = 6'd30; in_valid = 1;
    ha = frame[17:0]; hb = frame[35:18];
    tick();
    chk_out("sel0_30", ha, hb, 1, 1, 1'b1);
    build(3); sel_a = 6'd25; sel_b = 6'd1;
    tick(); in_valid = 0;
    chk_out("sel25_1", lv(3, 1, 0), lv(3, 1, 1), 1, 1, 1'b1);
    tick();

    // Round-robin scan over 26 back-to-back frames
    scan_mode = 1; in_valid = 1;
    for (int i = 0; i < 26; i++) begin
      build(16 + i);
      tick();
      chk_out($sformatf("scan%0d", i), lv(16 + i, (i % 24) + 1, 0), lv(16 + i, (i % 24) + 1, 1),
              (i % 24) + 1, (i % 24) + 1, 1'b1);
    end
    in_valid = 0; scan_mode = 0;
    tick();
    chk("scan.idle", 32'(out_valid), 32'd0);

    // Backpressure: held frame, three drops
    build(40); sel_a = 6'd5; sel_b = 6'd6; out_ready = 0; in_valid = 1;
    tick();
    chk_out("bp.load", lv(40, 5, 0), lv(40, 6, 1), 5, 6, 1'b1);
    for (int j = 0; j < 3; j++) begin
      build(41 + j);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("bp.hold", lv(40, 5, 0), lv(40, 6, 1), 5, 6, 1'b1);
    end
    in_valid = 0;
`ifdef ADC_CHANNEL_MUX_OVF_EN
    chk("bp.ovf", 32'(ovf), 32'd1);
    chk("bp.drop_cnt", 32'(drop_cnt), 32'd3);
`else
    chk("bp.ovf", 32'(ovf), 32'd0);
    chk("bp.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("clr.ovf", 32'(ovf), 32'd0);
    chk("clr.drop_cnt", 32'(drop_cnt), 32'd0);

    // Consume and accept in the same cycle
    build(50); sel_a = 6'd24; sel_b = 6'd1; out_ready = 1; in_valid = 1;
    tick();
    chk_out("thru0", lv(50, 24, 0), lv(50, 1, 1), 24, 1, 1'b1);
    build(51); sel_a = 6'd25; sel_b = 6'd63;
    tick(); in_valid = 0;
    chk_out("thru1", lv(51, 1, 0), lv(51, 1, 1), 1, 1, 1'b1);
    tick();
    chk("thru.idle", 32'(out_valid), 32'd0);

    // Scan counter holds across a dropped frame
    scan_mode = 1; out_ready = 0; build(60); in_valid = 1;
    tick();
    chk_out("sbp.load", lv(60, 1, 0), lv(60, 1, 1), 1, 1, 1'b1);
    build(61); tick();
    chk_out("sbp.hold", lv(60, 1, 0), lv(60, 1, 1), 1, 1, 1'b1);
    out_ready = 1; build(62); tick();
    chk_out("sbp.next", lv(62, 2, 0), lv(62, 2, 1), 2, 2, 1'b1);

    // Leaving scan mode restarts the counter
    scan_mode = 0; in_valid = 0; tick();
    scan_mode = 1; in_valid = 1; build(63); tick();
    chk_out("rescan0", lv(63, 1, 0), lv(63, 1, 1), 1, 1, 1'b1);
    build(64); tick();
    chk_out("rescan1", lv(64, 2, 0), lv(64, 2, 1), 2, 2, 1'b1);

    // Reset overrides a held frame and a pending accept
    out_ready = 0; build(65); tick();
    chk_out("pre_rst", lv(64, 2, 0), lv(64, 2, 1), 2, 2, 1'b1);
    rst = 1; out_ready = 1; tick(); rst = 0;
    chk_out("rst_mid", '0, '0, 1, 1, 1'b0);
    build(66); tick(); in_valid = 0;
    chk_out("post_rst", lv(66, 1, 0), lv(66, 1, 1), 1, 1, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
